led_status_sched: RTL and testbench

Round-robin scheduler that shares the single front-panel status LED between up to NUM_SRC status requesters. It grants the LED to one source per display slot and drives that source's 2-bit status code onto the `state` input of the LED blink indicator. Each slot lasts DWELL_CYCLES clocks, so every active source's blink pattern is shown for whole frames. A sticky fault override pre-empts rotation.

---
 rtl/led_status_sched.sv | 173 +++++++++++++++++
 tb/tb_led_status_sched.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/led_status_sched.sv
// Round-robin owner of the single front-panel status LED: each requester gets
// whole dwell slots in turn, and a sticky fault override pre-empts the rotation.
module led_status_sched #(
    parameter int NUM_SRC      = 4,
    parameter int SEL_W        = 2,
    parameter int DWELL_CYCLES = 64,
    parameter int CNT_W        = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [NUM_SRC-1:0]   src_req,
    input  logic [2*NUM_SRC-1:0] src_state,
    input  logic                 fault_clr,
    output logic [1:0]           state,
    output logic [SEL_W-1:0]     src_sel,
    output logic                 slot_start,
    output logic                 fault_latched
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        FAULT = 2'd2
    } fsm_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SRC - 1);

    fsm_t             fsm_reg, fsm_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       state_reg, state_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic             slot_start_reg, slot_start_next;
    logic             fault_reg, fault_next;
    logic [SEL_W-1:0] last_reg, last_next;

    logic [1:0]       src_code [NUM_SRC];
    logic [NUM_SRC-1:0] fault_vec;
    logic             any_fault;
    logic             any_req;
    logic [SEL_W-1:0] win_idx;
    logic [SEL_W-1:0] fault_idx;
    logic             grant;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_code[gi]  = src_state[2*gi +: 2];
            assign fault_vec[gi] = src_req[gi] & (src_state[2*gi +: 2] == 2'b11);
        end
    endgenerate

    assign any_fault = |fault_vec;
    assign any_req   = |src_req;

    // Circular scan starting just after the last granted source.
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] idx_s;
        found   = 1'b0;
        win_idx = '0;
        idx_s   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx_s = SEL_W'((int'(last_reg) + k) % NUM_SRC);
            if (!found && src_req[idx_s]) begin
                found   = 1'b1;
                win_idx = idx_s;
            end
        end
    end

    always_comb begin
        fault_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (fault_vec[i]) begin
                fault_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        fsm_next        = fsm_reg;
        cnt_next        = cnt_reg;
        state_next      = state_reg;
        sel_next        = sel_reg;
        slot_start_next = 1'b0;
        fault_next      = fault_reg;
        last_next       = last_reg;
        grant           = 1'b0;

        case (fsm_reg)
            IDLE: begin
                state_next = 2'd0;
                if (any_fault) begin
                    fsm_next   = FAULT;
                    sel_next   = fault_idx;
                    state_next = 2'd3;
                    fault_next = 1'b1;
                    cnt_next   = '0;
                end else if (any_req) begin
                    grant = 1'b1;
                end
            end
            SHOW: begin
                if (any_fault) begin
                    fsm_next   = FAULT;
                    sel_next   = fault_idx;
                    state_next = 2'd3;
                    fault_next = 1'b1;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (any_req) begin
                        grant = 1'b1;
                    end else begin
                        fsm_next   = IDLE;
                        state_next = 2'd0;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            FAULT: begin
                // Release only once the fault condition itself has gone away.
                if (fault_clr && !any_fault) begin
                    fsm_next   = IDLE;
                    state_next = 2'd0;
                    fault_next = 1'b0;
                end
            end
            default: begin
                fsm_next   = IDLE;
                state_next = 2'd0;
                fault_next = 1'b0;
                cnt_next   = '0;
            end
        endcase

        if (grant) begin
            fsm_next        = SHOW;
            sel_next        = win_idx;
            state_next      = src_code[win_idx];
            cnt_next        = '0;
            slot_start_next = 1'b1;
            last_next       = win_idx;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            fsm_reg        <= IDLE;
            cnt_reg        <= '0;
            state_reg      <= 2'd0;
            sel_reg        <= '0;
            slot_start_reg <= 1'b0;
            fault_reg      <= 1'b0;
            last_reg       <= SEL_LAST;
        end else begin
            fsm_reg        <= fsm_next;
            cnt_reg        <= cnt_next;
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            slot_start_reg <= slot_start_next;
            fault_reg      <= fault_next;
            last_reg       <= last_next;
        end
    end

    assign state         = state_reg;
    assign src_sel       = sel_reg;
    assign slot_start    = slot_start_reg;
    assign fault_latched = fault_reg;

endmodule

// File: tb/tb_led_status_sched.sv
// Directed bench for led_status_sched: a table of held-input segments with
// per-cycle expected outputs, followed by a few hand-written corner sequences.
module tb_led_status_sched;

    logic       clk;
    logic       rst;
    logic [3:0] src_req;
    logic [7:0] src_state;
    logic       fault_clr;
    logic [1:0] state;
    logic [1:0] src_sel;
    logic       slot_start;
    logic       fault_latched;

    int errors = 0;
    int checks = 0;

    led_status_sched #(
        .NUM_SRC(4),
        .SEL_W(2),
        .DWELL_CYCLES(64),
        .CNT_W(8)
    ) dut (
        .Clk(clk),
        .Rst(rst),
        .src_req(src_req),
        .src_state(src_state),
        .fault_clr(fault_clr),
        .state(state),
        .src_sel(src_sel),
        .slot_start(slot_start),
        .fault_latched(fault_latched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs held for n cycles; slot_start expected only on the first of them.
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [7:0] st;
        logic       clr;
        int         n;
        logic [1:0] e_state;
        logic [1:0] e_sel;
        logic       e_ss;
        logic       e_fl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic [7:0] st,
                       input logic c, input int n, input logic [1:0] es,
                       input logic [1:0] esel, input logic ess, input logic efl);
        vec_t v;
        v.rst = r; v.req = rq; v.st = st; v.clr = c; v.n = n;
        v.e_state = es; v.e_sel = esel; v.e_ss = ess; v.e_fl = efl;
        vecs.push_back(v);
    endtask

    task automatic check_out(input string name, input logic [1:0] es,
                             input logic [1:0] esel, input logic ess, input logic efl);
        checks++;
        if ({state, src_sel, slot_start, fault_latched} !== {es, esel, ess, efl}) begin
            errors++;
            $display("FAIL %s: got state=%0d sel=%0d ss=%0d fl=%0d, expected state=%0d sel=%0d ss=%0d fl=%0d",
                     name, state, src_sel, slot_start, fault_latched, es, esel, ess, efl);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        int found;
        int per;

        rst = 1'b1; src_req = '0; src_state = '0; fault_clr = 1'b0;

        // rst req   state         clr  n   st sel ss fl
        add(1, 4'b0000, 8'h00,        0,   3, 0, 0, 0, 0);  // reset
        add(0, 4'b0000, 8'h00,        0, 200, 0, 0, 0, 0);  // idle hold
        add(0, 4'b0001, 8'b00000010,  0,  64, 2, 0, 1, 0);  // lone source
        add(0, 4'b0001, 8'b00000010,  0,  64, 2, 0, 1, 0);  // wins again
        add(0, 4'b1011, 8'b00111001,  0,  64, 2, 1, 1, 0);  // rotation: 1
        add(0, 4'b1011, 8'b00111001,  0,  64, 0, 3, 1, 0);  // 3 (2 skipped)
        add(0, 4'b1011, 8'b00111001,  0,  64, 1, 0, 1, 0);  // 0
        add(0, 4'b1011, 8'b00111001,  0,  20, 2, 1, 1, 0);  // 1, cycles 0..19
        add(0, 4'b1001, 8'b00110101,  0,  44, 2, 1, 0, 0);  // code/req change ignored
        add(0, 4'b1001, 8'b00110101,  0,  64, 0, 3, 1, 0);  // next requester
        add(0, 4'b1001, 8'b00110101,  0,  10, 1, 0, 1, 0);  // source 0, cycles 0..9
        add(0, 4'b1101, 8'b00110101,  0,   1, 3, 2, 0, 1);  // fault entry
        add(0, 4'b1101, 8'b00110101,  1,   1, 3, 2, 0, 1);  // clr ignored
        add(0, 4'b1001, 8'b00110101,  0,   5, 3, 2, 0, 1);  // sticky
        add(0, 4'b1001, 8'b00110101,  1,   1, 0, 2, 0, 0);  // released to IDLE
        add(0, 4'b1001, 8'b00110101,  0,  64, 0, 3, 1, 0);  // slot_start at t+2
        add(0, 4'b1001, 8'b00110101,  0,  30, 1, 0, 1, 0);  // source 0 slot
        add(1, 4'b1011, 8'b00111001,  0,   1, 0, 0, 0, 0);  // reset mid-slot
        add(0, 4'b1011, 8'b00111001,  0,  10, 1, 0, 1, 0);  // pointer reset: 0 first
        add(0, 4'b1111, 8'b00111001,  0,   1, 3, 2, 0, 1);  // fault
        add(1, 4'b0000, 8'h00,        0,   1, 0, 0, 0, 0);  // reset mid-fault
        add(0, 4'b0001, 8'b00111001,  0,  63, 1, 0, 1, 0);  // cycles 0..62
        add(0, 4'b0000, 8'b00111001,  0,   1, 1, 0, 0, 0);  // cycle 63 still shown
        add(0, 4'b0000, 8'b00111001,  0,   3, 0, 0, 0, 0);  // no requester -> IDLE
        add(0, 4'b1111, 8'b11011101,  0,   1, 3, 1, 0, 1);  // lowest faulting index
        add(0, 4'b0000, 8'h00,        1,   1, 0, 1, 0, 0);  // clear
        add(0, 4'b0000, 8'h00,        0,   2, 0, 1, 0, 0);

        foreach (vecs[v]) begin
            rst       = vecs[v].rst;
            src_req   = vecs[v].req;
            src_state = vecs[v].st;
            fault_clr = vecs[v].clr;
            for (int c = 0; c < vecs[v].n; c++) begin
                @(negedge clk);
                check_out($sformatf("vec%0d_cyc%0d", v, c), vecs[v].e_state, vecs[v].e_sel,
                          (c == 0) ? vecs[v].e_ss : 1'b0, vecs[v].e_fl);
            end
            $display("vec %0d: rst=%0b req=%b st=%h clr=%0b held %0d cycles", v,
                     vecs[v].rst, vecs[v].req, vecs[v].st, vecs[v].clr, vecs[v].n);
        end

        // Slot period measured between consecutive slot_start pulses.
        src_req = 4'b0001; src_state = 8'b00000010; fault_clr = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (slot_start) found = 1;
        end
        check_int("first_slot_start_seen", found, 1);
        found = 0; per = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            per++;
            if (slot_start) found = 1;
        end
        check_int("slot_period", per, 64);
        check_out("period_slot_out", 2, 0, 1, 0);
        $display("seq period: measured %0d cycles", per);

        // Fault arriving on the last dwell cycle beats the re-arbitration.
        repeat (63) @(negedge clk);
        src_state = 8'b00000011;
        @(negedge clk);
        check_out("fault_beats_expiry", 3, 0, 0, 1);
        src_req = 4'b0000; src_state = 8'h00; fault_clr = 1'b1;
        @(negedge clk);
        check_out("fault_release", 0, 0, 0, 0);
        fault_clr = 1'b0;
        $display("seq fault-at-expiry done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
